// File: rtl/data_bus_responder_if.sv
// rtl/data_bus_responder_if.sv - data bus request/response signals between core (master) and responder (slave)
interface data_bus_responder_if;
  logic        bus_rden;
  logic        bus_wren;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_size;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_error;
  logic        busy;

  modport master (
    output bus_rden, bus_wren, bus_addr, bus_wdata, bus_size,
    input  bus_rdata, bus_ready, bus_error, busy
  );

  modport slave (
    input  bus_rden, bus_wren, bus_addr, bus_wdata, bus_size,
    output bus_rdata, bus_ready, bus_error, busy
  );
endinterface

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data RAM target with wait states, lane handling and error reporting
// Optional word register at BASE_ADDR+4*DEPTH_WORDS when DATA_BUS_RESPONDER_MMIO_EN is defined.
module data_bus_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_responder_if.slave  bus
`ifdef DATA_BUS_RESPONDER_MMIO_EN
  ,
  output logic [31:0]          mmio_out
`endif
);
  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [31:0] rdata_q;
  logic        ready_q, error_q, busy_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req_in, idle, commit;
  logic        sel_rd, sel_wr;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_size;
  logic [31:0] offset;
  logic [IDX_W-1:0] mem_idx;
  logic        in_ram, mmio_hit, is_h, is_w, err;
  logic [31:0] rd_word, load_val, wd;
  logic [3:0]  be;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_in = bus.bus_rden | bus.bus_wren;
  assign idle   = (state == S_IDLE);

  // With zero wait states the side effects happen on the accepting edge, so decode the live inputs.
  assign sel_rd    = idle ? bus.bus_rden  : req_rd;
  assign sel_wr    = idle ? bus.bus_wren  : req_wr;
  assign sel_addr  = idle ? bus.bus_addr  : req_addr;
  assign sel_wdata = idle ? bus.bus_wdata : req_wdata;
  assign sel_size  = idle ? bus.bus_size  : req_size;

  assign commit = (idle && req_in && (WAIT_STATES == 0)) ||
                  ((state == S_WAIT) && (cnt == 4'd0));

  assign offset  = sel_addr - BASE_ADDR;
  assign mem_idx = IDX_W'(offset >> 2);
  assign in_ram  = (sel_addr >= BASE_ADDR) && (sel_addr < END_ADDR);
`ifdef DATA_BUS_RESPONDER_MMIO_EN
  assign mmio_hit = (sel_addr == END_ADDR);
  assign rd_word  = mmio_hit ? mmio_out : mem[mem_idx];
`else
  assign mmio_hit = 1'b0;
  assign rd_word  = mem[mem_idx];
`endif

  assign is_h = (sel_size == 3'b001) || (sel_size == 3'b101);
  assign is_w = (sel_size == 3'b010);

  assign err = (sel_rd && sel_wr) ||
               (is_h && sel_addr[0]) ||
               (is_w && (sel_addr[1:0] != 2'b00)) ||
               !(in_ram || mmio_hit) ||
               (mmio_hit && !is_w) ||
               (sel_size == 3'b011) || (sel_size == 3'b110) || (sel_size == 3'b111) ||
               (sel_wr && sel_size[2]);

  always_comb begin
    lane_b = rd_word[7:0];
    case (sel_addr[1:0])
      2'b01:   lane_b = rd_word[15:8];
      2'b10:   lane_b = rd_word[23:16];
      2'b11:   lane_b = rd_word[31:24];
      default: lane_b = rd_word[7:0];
    endcase
    lane_h = sel_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (sel_size)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = rd_word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the lanes that land.
  always_comb begin
    be = 4'b1111;
    wd = sel_wdata;
    case (sel_size[1:0])
      2'b00: begin
        be = 4'b0001 << sel_addr[1:0];
        wd = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        be = sel_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{sel_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = sel_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && sel_wr && !err && in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[mem_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_size  <= 3'd0;
      rdata_q   <= 32'd0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DATA_BUS_RESPONDER_MMIO_EN
      mmio_out  <= 32'd0;
`endif
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_in) begin
            req_rd    <= bus.bus_rden;
            req_wr    <= bus.bus_wren;
            req_addr  <= bus.bus_addr;
            req_wdata <= bus.bus_wdata;
            req_size  <= bus.bus_size;
            busy_q    <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        ready_q <= 1'b1;
        error_q <= err;
        if (sel_rd) rdata_q <= err ? 32'd0 : load_val;
`ifdef DATA_BUS_RESPONDER_MMIO_EN
        if (sel_wr && !err && mmio_hit) mmio_out <= sel_wdata;
`endif
      end
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.bus_ready = ready_q;
  assign bus.bus_error = error_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - scoreboard bench for data_bus_responder (WAIT_STATES=1 and 0 instances)
module tb_data_bus_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_bus_responder_if ba();
  data_bus_responder_if bb();

`ifdef DATA_BUS_RESPONDER_MMIO_EN
  logic [31:0] mmio_a, mmio_b;
`endif

  data_bus_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ba)
`ifdef DATA_BUS_RESPONDER_MMIO_EN
    , .mmio_out(mmio_a)
`endif
  );

  data_bus_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bb)
`ifdef DATA_BUS_RESPONDER_MMIO_EN
    , .mmio_out(mmio_b)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t0;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_BU = 3'b100, SZ_HU = 3'b101;

`ifdef DATA_BUS_RESPONDER_MMIO_EN
  localparam logic        MMIO_ERR   = 1'b0;
  localparam logic [31:0] RD_BEFORE8 = 32'h0000_0005;
`else
  localparam logic        MMIO_ERR   = 1'b1;
  localparam logic [31:0] RD_BEFORE8 = 32'h1234_A5EF;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ba.bus_ready) begin
      if (qa.size() == 0) chk("a_unexpected_ready", {31'd0, ba.bus_ready}, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_rdata", ba.bus_rdata, e.rdata);
        chk("a_error", {31'd0, ba.bus_error}, {31'd0, e.err});
        chk("a_latency", cyc - e.t0, 32'd2);
      end
    end else if (ba.bus_error) chk("a_error_without_ready", {31'd0, ba.bus_error}, 32'd0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (bb.bus_ready) begin
      if (qb.size() == 0) chk("b_unexpected_ready", {31'd0, bb.bus_ready}, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_rdata", bb.bus_rdata, e.rdata);
        chk("b_error", {31'd0, bb.bus_error}, {31'd0, e.err});
        chk("b_latency", cyc - e.t0, 32'd1);
      end
    end else if (bb.bus_error) chk("b_error_without_ready", {31'd0, bb.bus_error}, 32'd0);
  end

  task automatic issue(input bit which, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int n;
    logic rdy;
    @(negedge clk);
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.t0    = cyc;
    if (which) begin
      bb.bus_rden = rd; bb.bus_wren = wr; bb.bus_addr = addr; bb.bus_wdata = wdata; bb.bus_size = size;
      qb.push_back(e);
    end else begin
      ba.bus_rden = rd; ba.bus_wren = wr; ba.bus_addr = addr; ba.bus_wdata = wdata; ba.bus_size = size;
      qa.push_back(e);
    end
    @(posedge clk);
    #1;
    if (which) begin bb.bus_rden = 1'b0; bb.bus_wren = 1'b0; end
    else       begin ba.bus_rden = 1'b0; ba.bus_wren = 1'b0; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rdy = which ? bb.bus_ready : ba.bus_ready;
    end while (!rdy && n < 20);
    if (!rdy) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    ba.bus_rden = 0; ba.bus_wren = 0; ba.bus_addr = 0; ba.bus_wdata = 0; ba.bus_size = 0;
    bb.bus_rden = 0; bb.bus_wren = 0; bb.bus_addr = 0; bb.bus_wdata = 0; bb.bus_size = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", ba.bus_rdata, 32'd0);
    chk("reset_ready", {31'd0, ba.bus_ready}, 32'd0);
    chk("reset_error", {31'd0, ba.bus_error}, 32'd0);
    chk("reset_busy",  {31'd0, ba.busy}, 32'd0);
    rst = 1'b0;

    // basic word and sub-word traffic, WAIT_STATES=1
    issue(0, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF, SZ_W,  32'h0000_0000, 0);
    issue(0, 1, 0, 32'h1001_0004, 32'h0,         SZ_W,  32'hDEAD_BEEF, 0);
    issue(0, 0, 1, 32'h1001_0005, 32'h0000_00A5, SZ_B,  32'hDEAD_BEEF, 0);
    issue(0, 1, 0, 32'h1001_0005, 32'h0,         SZ_B,  32'hFFFF_FFA5, 0);
    issue(0, 1, 0, 32'h1001_0005, 32'h0,         SZ_BU, 32'h0000_00A5, 0);
    issue(0, 1, 0, 32'h1001_0004, 32'h0,         SZ_W,  32'hDEAD_A5EF, 0);
    issue(0, 0, 1, 32'h1001_0006, 32'h0000_1234, SZ_H,  32'hDEAD_A5EF, 0);
    issue(0, 1, 0, 32'h1001_0006, 32'h0,         SZ_HU, 32'h0000_1234, 0);

    // illegal accesses, each followed by a readback showing the word untouched
    issue(0, 1, 0, 32'h1001_0001, 32'h0,         SZ_H,   32'h0000_0000, 1);
    issue(0, 1, 0, 32'h1001_0004, 32'h0,         SZ_W,   32'h1234_A5EF, 0);
    issue(0, 1, 0, 32'h1001_0002, 32'h0,         SZ_W,   32'h0000_0000, 1);
    issue(0, 1, 0, 32'h1001_0400, 32'h0,         SZ_W,   32'h0000_0000, MMIO_ERR);
    issue(0, 1, 1, 32'h1001_0004, 32'hFFFF_FFFF, SZ_W,   32'h0000_0000, 1);
    issue(0, 1, 0, 32'h1001_0004, 32'h0,         SZ_W,   32'h1234_A5EF, 0);
    issue(0, 1, 0, 32'h1001_0004, 32'h0,         3'b011, 32'h0000_0000, 1);
    issue(0, 0, 1, 32'h1001_0004, 32'hFFFF_FFFF, SZ_BU,  32'h0000_0000, 1);
    issue(0, 1, 0, 32'h1001_0004, 32'h0,         SZ_W,   32'h1234_A5EF, 0);
    issue(0, 0, 1, 32'h1001_0400, 32'h0000_0005, SZ_W,   32'h1234_A5EF, MMIO_ERR);
`ifdef DATA_BUS_RESPONDER_MMIO_EN
    chk("mmio_out_in_ready", mmio_a, 32'h0000_0005);
    issue(0, 1, 0, 32'h1001_0400, 32'h0,         SZ_W,   32'h0000_0005, 0);
    issue(0, 0, 1, 32'h1001_0400, 32'h0000_0077, SZ_B,   32'h0000_0005, 1);
    chk("mmio_out_after_sb", mmio_a, 32'h0000_0005);
`endif

    // reset during WAIT discards the pending store
    issue(0, 0, 1, 32'h1001_0008, 32'h2222_2222, SZ_W, RD_BEFORE8, 0);
    @(negedge clk);
    ba.bus_wren = 1; ba.bus_addr = 32'h1001_0008; ba.bus_wdata = 32'h1111_1111; ba.bus_size = SZ_W;
    @(posedge clk);
    #1 ba.bus_wren = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  {31'd0, ba.busy}, 32'd0);
    chk("abort_rdata", ba.bus_rdata, 32'd0);
    repeat (3) @(negedge clk);
    issue(0, 1, 0, 32'h1001_0008, 32'h0, SZ_W, 32'h2222_2222, 0);

    // WAIT_STATES=0: single access, then a request held high across several cycles
    issue(1, 0, 1, 32'h1001_0010, 32'hCAFE_F00D, SZ_W, 32'h0000_0000, 0);
    @(negedge clk);
    bb.bus_rden = 1; bb.bus_addr = 32'h1001_0010; bb.bus_size = SZ_W;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        e.rdata = 32'hCAFE_F00D; e.err = 1'b0; e.t0 = cyc;
        qb.push_back(e);
      end
      @(negedge clk);
    end
    bb.bus_rden = 0;
    repeat (5) @(negedge clk);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Target side of the core's data bus. Answers the load/store requests that the multi-cycle control unit raises in its MEM state through bus_rden/bus_wren.
- Contains a word-organised data RAM with byte/halfword lane handling and sign/zero extension.
- Adds a programmable wait-state counter and a completion pulse (bus_ready), so the core can later stall MEM on slow memory.
- Flags illegal accesses with bus_error.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words.
- BASE_ADDR, 32'h1001_0000, byte address of word 0.
- WAIT_STATES, 1, extra cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- bus_rden  in  1  read request, sampled only in IDLE.
- bus_wren  in  1  write request, sampled only in IDLE.
- bus_addr  in  32  byte address.
- bus_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- bus_size  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- bus_rdata  out  32  load result, extended, registered.
- bus_ready  out  1  one-cycle completion pulse.
- bus_error  out  1  high together with bus_ready when the access was illegal.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, wait counter=0, bus_rdata=0, bus_ready=0, bus_error=0, busy=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If bus_rden|bus_wren, latch addr, wdata, size and op.
  - Go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else go directly to RESP.
- WAIT: decrement the counter; when counter==0, go to RESP.
- RESP:
  - bus_ready=1 for exactly this one cycle, then return to IDLE.
  - Latency: bus_ready is high exactly WAIT_STATES+1 cycles after the accepting cycle.
- Requests arriving in WAIT or RESP are ignored, not queued. A new request can be accepted in the cycle after RESP.
- Side effects happen on the edge entering RESP:
  - Write commits to RAM.
  - Read loads bus_rdata.
  - bus_rdata holds its value until the next completed read.
  - A write never changes bus_rdata.
- Word index = (bus_addr-BASE_ADDR)>>2. Lane select = addr[1:0].
- Stores:
  - SB writes one byte lane.
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Other lanes are unchanged.
- Loads:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW returns the word.
- Error conditions, evaluated on the latched request:
  - bus_rden and bus_wren both high.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Address below BASE_ADDR or at/above BASE_ADDR+4*DEPTH_WORDS.
  - bus_size of 011, 110 or 111.
  - BU/HU code on a write.
- On error:
  - Same latency as a normal access.
  - bus_error=1 with bus_ready.
  - No RAM change; bus_rdata loads 0 for reads and is unchanged for writes.
- bus_error is 0 whenever bus_ready is 0.
- Reset mid-operation (WAIT or RESP not yet reached):
  - The access is aborted and a pending write is discarded.
  - No bus_ready pulse is produced for the aborted access.

Optional Feature:
- Macro: DATA_BUS_RESPONDER_MMIO_EN.
- Defined:
  - Adds output port mmio_out [31:0], a register that resets to 0.
  - Register address is BASE_ADDR+4*DEPTH_WORDS.
  - Only word accesses are legal there; sub-word accesses to that address raise bus_error.
  - SW updates the register on the edge entering RESP; LW returns its value.
  - Same latency and ready/error rules as RAM accesses.
- Undefined: the port is absent and that address is out of range (error).

Test Plan:
1. WAIT_STATES=1. SW 0xDEADBEEF @0x1001_0004, then LW @0x1001_0004 → each bus_ready exactly 2 cycles after request; rdata=0xDEADBEEF; error=0.
2. After test 1:
   - SB wdata 0xA5 @0x1001_0005.
   - LB @0x1001_0005 → 0xFFFFFFA5.
   - LBU → 0x000000A5.
   - LW @0x1001_0004 → 0xDEADA5EF.
   - SH 0x1234 @0x1001_0006, then LHU → 0x00001234.
3. Illegal accesses, each gives ready+error after 2 cycles with rdata=0 and a following LW showing RAM unchanged:
   - LH @0x1001_0001.
   - LW @0x1001_0002.
   - LW @0x1001_0400 (macro off).
   - rden&wren together.
   - size=011.
4. WAIT_STATES=0 → ready 1 cycle after request; back-to-back requests issued on every IDLE cycle complete every 2 cycles; a request held during RESP is not double-accepted.
5. SW 0x11111111 @0x1001_0008, then rst asserted in the WAIT cycle → no ready pulse; busy=0 after reset; subsequent LW returns the prior contents.
6. Macro on: SW 0x5 @0x1001_0400 → mmio_out=0x5 in the ready cycle; LW there → 0x5; SB there → error. Macro off: SW there → error.
